// File: rtl/em_educ8_pkg.sv
// Shared EDUC-8 sequencer types: major-cycle encodings, opcode constants, default slot count
// and the major-cycle transition rule used at every cycle end.
package em_educ8_pkg;

  localparam int NT_DEFAULT = 8;

  typedef enum logic [1:0] {
    MAJ_FETCH = 2'b00,
    MAJ_DEFER = 2'b01,
    MAJ_EXEC  = 2'b10
  } major_t;

  localparam logic [2:0] OP_JMP = 3'd5;
  localparam logic [2:0] OP_IOT = 3'd6;
  localparam logic [2:0] OP_OPR = 3'd7;

  // Major cycle that follows cur for the given opcode / indirect bit.
  function automatic major_t next_major(input major_t cur, input logic [2:0] op, input logic ind);
    major_t nxt;
    nxt = MAJ_FETCH;
    case (cur)
      MAJ_FETCH: begin
        if (op == OP_IOT || op == OP_OPR) nxt = MAJ_FETCH;
        else if (ind)                     nxt = MAJ_DEFER;
        else if (op == OP_JMP)            nxt = MAJ_FETCH;
        else                              nxt = MAJ_EXEC;
      end
      MAJ_DEFER: nxt = (op < OP_JMP) ? MAJ_EXEC : MAJ_FETCH;
      default:   nxt = MAJ_FETCH;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/em_timing_ctrl_if.sv
// Front-panel/IR inputs and timing outputs of the EDUC-8 sequencer; slave = sequencer side.
// Define EM_CYCLE_STEP_EN to add the cycle-step switch.
interface em_timing_ctrl_if #(
  parameter int NT = em_educ8_pkg::NT_DEFAULT
);
  logic          run_sw;
  logic          stop_sw;
  logic          sstep_sw;
  logic          halt_req;
  logic [2:0]    ir_op;
  logic          ir_ind;
`ifdef EM_CYCLE_STEP_EN
  logic          cstep_sw;
`endif
  logic [NT-1:0] tstate;
  logic [1:0]    major;
  logic          running;
  logic          cyc_end;
  logic          instr_end;

  modport slave (
    input  run_sw, stop_sw, sstep_sw, halt_req, ir_op, ir_ind,
`ifdef EM_CYCLE_STEP_EN
    input  cstep_sw,
`endif
    output tstate, major, running, cyc_end, instr_end
  );

  modport master (
    output run_sw, stop_sw, sstep_sw, halt_req, ir_op, ir_ind,
`ifdef EM_CYCLE_STEP_EN
    output cstep_sw,
`endif
    input  tstate, major, running, cyc_end, instr_end
  );
endinterface

// File: rtl/em_slot_counter.sv
// Mod-NT slot counter: synchronous clear beats enable, wraps NT-1 -> 0, tc flags slot NT-1.
// Single-cycle registered count; no backpressure.
module em_slot_counter #(
  parameter int NT = em_educ8_pkg::NT_DEFAULT,
  localparam int W = $clog2(NT)
) (
  input  logic         clk,
  input  logic         nclr,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         tc
);

  assign tc = (cnt == W'(NT - 1));

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + W'(1);
    end
  end

endmodule

// File: rtl/em_timing_ctrl.sv
// EDUC-8 major-state / timing-slot sequencer; outputs decode registered state, start edge -> slot 0 next clock, no backpressure.
// EM_CYCLE_STEP_EN adds cstep_sw: run one major cycle, halt keeping the major state.
module em_timing_ctrl #(
  parameter int NT = em_educ8_pkg::NT_DEFAULT
) (
  input  logic            clk,
  input  logic            nclr,
  em_timing_ctrl_if.slave bus
);
  import em_educ8_pkg::*;

  localparam int W = $clog2(NT);

  logic         running_q, running_d;
  major_t       major_q, major_d;
  logic         step_pend_q, step_pend_d;
  logic         stop_pend_q, stop_pend_d;
  logic         run_hist_q, sstep_hist_q;
  logic         run_rise, sstep_rise, start_edge;
  logic [W-1:0] slot;
  logic         slot_tc;
  logic         cyc_end, instr_end;
  major_t       maj_after;
`ifdef EM_CYCLE_STEP_EN
  logic         cstep_hist_q, cstep_rise;
  logic         cyc_pend_q, cyc_pend_d;
`endif

  // Slot is held at zero while halted, so a start always begins at slot 0.
  em_slot_counter #(.NT(NT)) u_slot (
    .clk  (clk),
    .nclr (nclr),
    .clr  (~running_q),
    .en   (running_q),
    .cnt  (slot),
    .tc   (slot_tc)
  );

  assign run_rise   = bus.run_sw & ~run_hist_q;
  assign sstep_rise = bus.sstep_sw & ~sstep_hist_q;
`ifdef EM_CYCLE_STEP_EN
  assign cstep_rise = bus.cstep_sw & ~cstep_hist_q;
  assign start_edge = run_rise | sstep_rise | cstep_rise;
`else
  assign start_edge = run_rise | sstep_rise;
`endif

  assign maj_after = next_major(major_q, bus.ir_op, bus.ir_ind);
  assign cyc_end   = running_q & slot_tc;
  assign instr_end = cyc_end & (maj_after == MAJ_FETCH);

  always_comb begin
    running_d   = running_q;
    major_d     = major_q;
    step_pend_d = step_pend_q;
    stop_pend_d = stop_pend_q;
`ifdef EM_CYCLE_STEP_EN
    cyc_pend_d  = cyc_pend_q;
`endif
    if (!running_q) begin
      if (start_edge && !bus.stop_sw) begin
        running_d   = 1'b1;
        step_pend_d = sstep_rise;
`ifdef EM_CYCLE_STEP_EN
        cyc_pend_d  = cstep_rise;
`else
        major_d     = MAJ_FETCH;
`endif
      end
    end else begin
      if (bus.stop_sw) stop_pend_d = 1'b1;
      if (cyc_end) begin
        major_d = maj_after;
        // Pending stops only take effect between instructions.
        if (instr_end && (stop_pend_q || step_pend_q || bus.halt_req)) begin
          running_d   = 1'b0;
          major_d     = MAJ_FETCH;
          stop_pend_d = 1'b0;
          step_pend_d = 1'b0;
        end
`ifdef EM_CYCLE_STEP_EN
        if (cyc_pend_q) begin
          running_d   = 1'b0;
          stop_pend_d = 1'b0;
          step_pend_d = 1'b0;
          cyc_pend_d  = 1'b0;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk or negedge nclr) begin
    if (!nclr) begin
      running_q    <= 1'b0;
      major_q      <= MAJ_FETCH;
      step_pend_q  <= 1'b0;
      stop_pend_q  <= 1'b0;
      run_hist_q   <= 1'b0;
      sstep_hist_q <= 1'b0;
`ifdef EM_CYCLE_STEP_EN
      cyc_pend_q   <= 1'b0;
      cstep_hist_q <= 1'b0;
`endif
    end else begin
      running_q    <= running_d;
      major_q      <= major_d;
      step_pend_q  <= step_pend_d;
      stop_pend_q  <= stop_pend_d;
      run_hist_q   <= bus.run_sw;
      sstep_hist_q <= bus.sstep_sw;
`ifdef EM_CYCLE_STEP_EN
      cyc_pend_q   <= cyc_pend_d;
      cstep_hist_q <= bus.cstep_sw;
`endif
    end
  end

  assign bus.tstate    = running_q ? (NT'(1) << slot) : '0;
  assign bus.major     = major_q;
  assign bus.running   = running_q;
  assign bus.cyc_end   = cyc_end;
  assign bus.instr_end = instr_end;

endmodule

// File: tb/tb_em_timing_ctrl.sv
// Bench for em_timing_ctrl: instruction-level reference model checked every cycle plus directed scenarios.
module tb_em_timing_ctrl;
  localparam int NT = 8;

  logic clk = 1'b0;
  logic nclr = 1'b0;
  int total = 0;
  int passed = 0;

  em_timing_ctrl_if #(.NT(NT)) bus ();

  em_timing_ctrl #(.NT(NT)) dut (
    .clk  (clk),
    .nclr (nclr),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  // 0 FETCH, 1 DEFER, 2 EXEC
  function automatic int major_after(input int cur, input int op, input int ind);
    if (cur == 0) begin
      if (op >= 6) return 0;
      if (ind != 0) return 1;
      return (op == 5) ? 0 : 2;
    end
    if (cur == 1) return (op <= 4) ? 2 : 0;
    return 0;
  endfunction

  // Reference model: where the machine is within the current instruction.
  int m_run, m_slot, m_maj, m_stp, m_spd, m_hr, m_hs;
  always @(posedge clk or negedge nclr) begin : model
    int nm;
    if (!nclr) begin
      m_run = 0; m_slot = 0; m_maj = 0; m_stp = 0; m_spd = 0; m_hr = 0; m_hs = 0;
    end else begin
      if (m_run == 0) begin
        if (!bus.stop_sw && ((bus.run_sw && m_hr == 0) || (bus.sstep_sw && m_hs == 0))) begin
          m_run = 1; m_slot = 0; m_maj = 0;
          m_spd = (bus.sstep_sw && m_hs == 0) ? 1 : 0;
        end
      end else if (m_slot == NT - 1) begin
        nm = major_after(m_maj, bus.ir_op, bus.ir_ind);
        if (nm == 0 && (m_stp != 0 || m_spd != 0 || bus.halt_req)) begin
          m_run = 0; m_slot = 0; m_maj = 0; m_stp = 0; m_spd = 0;
        end else begin
          m_maj = nm; m_slot = 0;
          if (bus.stop_sw) m_stp = 1;
        end
      end else begin
        m_slot++;
        if (bus.stop_sw) m_stp = 1;
      end
      m_hr = bus.run_sw;
      m_hs = bus.sstep_sw;
    end
  end

  always @(negedge clk) begin : compare
    int e_ts, e_ce, e_ie;
    e_ts = (m_run != 0) ? (1 << m_slot) : 0;
    e_ce = (m_run != 0 && m_slot == NT - 1) ? 1 : 0;
    e_ie = (e_ce != 0 && major_after(m_maj, bus.ir_op, bus.ir_ind) == 0) ? 1 : 0;
    chk("m_tstate", int'(bus.tstate), e_ts);
    chk("m_major", int'(bus.major), m_maj);
    chk("m_running", int'(bus.running), m_run);
    chk("m_cyc_end", int'(bus.cyc_end), e_ce);
    chk("m_instr_end", int'(bus.instr_end), e_ie);
  end

  int cap_ts[64], cap_maj[64], cap_ie[64], cap_run[64];

  task automatic tick();
    @(posedge clk);
    #3;
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      cap_ts[i] = int'(bus.tstate); cap_maj[i] = int'(bus.major);
      cap_ie[i] = int'(bus.instr_end); cap_run[i] = int'(bus.running);
      tick();
    end
  endtask

  function automatic int sum_ie(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += cap_ie[i];
    return s;
  endfunction

  function automatic int sum_run(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += cap_run[i];
    return s;
  endfunction

  function automatic int max_maj(input int n);
    int m = 0;
    for (int i = 0; i < n; i++) if (cap_maj[i] > m) m = cap_maj[i];
    return m;
  endfunction

  task automatic start_run();
    bus.run_sw = 1'b1; tick(); bus.run_sw = 1'b0;
  endtask

  task automatic halt_now();
    bus.stop_sw = 1'b1; tick(); bus.stop_sw = 1'b0;
    for (int i = 0; i < 60 && bus.running; i++) tick();
    chk("halt_reached", int'(bus.running), 0);
  endtask

  initial begin : stim
    int ok;
    bus.run_sw = 0; bus.stop_sw = 0; bus.sstep_sw = 0; bus.halt_req = 0;
    bus.ir_op = 3'd7; bus.ir_ind = 0;
    tick(); tick();
    chk("rst_running", int'(bus.running), 0);
    chk("rst_tstate", int'(bus.tstate), 0);
    chk("rst_major", int'(bus.major), 0);
    chk("rst_instr_end", int'(bus.instr_end), 0);
    nclr = 1'b1;
    tick();

    // OPR: single FETCH cycle, walking tstate
    start_run();
    capture(24);
    ok = 1;
    for (int i = 0; i < 8; i++) if (cap_ts[i] != (1 << i)) ok = 0;
    chk("opr_walk", ok, 1);
    chk("opr_ie_count", sum_ie(24), 3);
    chk("opr_major", max_maj(24), 0);
    halt_now();

    // op 1 indirect: FETCH, DEFER, EXEC
    bus.ir_op = 3'd1; bus.ir_ind = 1;
    start_run();
    capture(24);
    chk("ind_maj0", cap_maj[0], 0);
    chk("ind_maj8", cap_maj[8], 1);
    chk("ind_maj16", cap_maj[16], 2);
    chk("ind_ie_count", sum_ie(24), 1);
    chk("ind_ie_last", cap_ie[23], 1);
    halt_now();

    // JMP direct then indirect
    bus.ir_op = 3'd5; bus.ir_ind = 0;
    start_run();
    capture(16);
    chk("jmp_ie_count", sum_ie(16), 2);
    chk("jmp_major", max_maj(16), 0);
    halt_now();
    bus.ir_ind = 1;
    start_run();
    capture(16);
    chk("jmpi_maj8", cap_maj[8], 1);
    chk("jmpi_ie_count", sum_ie(16), 1);
    chk("jmpi_no_exec", max_maj(16), 1);
    halt_now();

    // stop during DEFER slot 2 of op 2 indirect
    bus.ir_op = 3'd2; bus.ir_ind = 1;
    start_run();
    capture(10);
    chk("stop_in_defer", int'(bus.major), 1);
    chk("stop_slot2", int'(bus.tstate), 4);
    bus.stop_sw = 1; tick(); bus.stop_sw = 0;
    capture(14);
    chk("stop_exec_last_run", cap_run[12], 1);
    chk("stop_exec_last_ie", cap_ie[12], 1);
    chk("stop_exec_maj", cap_maj[12], 2);
    chk("stop_after_run", cap_run[13], 0);
    chk("stop_after_ts", cap_ts[13], 0);

    // single step, switch held
    bus.ir_op = 3'd3; bus.ir_ind = 0;
    bus.sstep_sw = 1; tick();
    capture(40);
    chk("sstep_clocks", sum_run(40), 16);
    bus.sstep_sw = 0; tick();

    // HLT microinstruction
    bus.ir_op = 3'd7; bus.halt_req = 1;
    start_run();
    capture(20);
    chk("hlt_clocks", sum_run(20), 8);
    bus.halt_req = 0;

    // reset in EXEC slot 5, then stop+run together
    bus.ir_op = 3'd1; bus.ir_ind = 0;
    start_run();
    capture(13);
    chk("pre_rst_major", int'(bus.major), 2);
    chk("pre_rst_ts", int'(bus.tstate), 32);
    #1 nclr = 1'b0;
    #1;
    chk("arst_running", int'(bus.running), 0);
    chk("arst_tstate", int'(bus.tstate), 0);
    chk("arst_major", int'(bus.major), 0);
    tick(); tick();
    nclr = 1'b1;
    tick();
    bus.stop_sw = 1; bus.run_sw = 1;
    tick();
    capture(5);
    chk("stop_blocks_start", sum_run(5), 0);
    bus.run_sw = 0; bus.stop_sw = 0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
